uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 204 ++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with a small transmit FIFO.
// Frame format: start bit, DATA_BITS data bits LSB first, optional parity,
// then STOP_BITS stop bits. Each line bit lasts CLK_FREQ/UART_BPS clocks.
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_CYC = CLK_FREQ / UART_BPS;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNTF_W  = PTR_W + 1;
  // Baud counter must reach 2*BIT_CYC-1 for a double stop bit.
  localparam int CNT_W   = $clog2(2 * BIT_CYC + 1);
  localparam int IDX_W   = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS * BIT_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [CNTF_W-1:0] DEPTH_C   = CNTF_W'(FIFO_DEPTH);
  localparam logic              HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  // Parity of a word: even parity is the XOR of the bits, odd is its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
    logic p;
    p = ^data;
    return (PARITY == 1) ? ~p : p;
  endfunction

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNTF_W-1:0]    r_count;

  // Transmit FSM state
  state_t               r_state;
  logic [CNT_W-1:0]     r_baud;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_txd;
  logic                 r_busy;

  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_has_word;
  logic                 w_stop_done;
  logic [DATA_BITS-1:0] w_head;

  // Handshake and pop decisions; a pop only ever happens when the FSM starts a frame.
  always_comb begin
    w_ready     = (r_count < DEPTH_C);
    w_push      = tx_valid & w_ready;
    w_has_word  = (r_count != CNTF_W'(0));
    w_stop_done = (r_state == ST_STOP) && (r_baud == STOP_LAST);
    w_pop       = w_has_word && ((r_state == ST_IDLE) || w_stop_done);
    w_head      = r_mem[r_rd_ptr];
  end

  // FIFO data storage; contents become unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNTF_W'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTF_W'(1);
        2'b01:   r_count <= r_count - CNTF_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame sequencer: latches the head word, shifts it out and drives the line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_baud    <= CNT_W'(0);
      r_bit_idx <= IDX_W'(0);
      r_shift   <= DATA_BITS'(0);
      r_par     <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_baud <= CNT_W'(0);
          if (w_pop) begin
            r_state <= ST_START;
            r_shift <= w_head;
            r_par   <= parity_bit(w_head);
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (r_baud == BIT_LAST) begin
            r_state   <= ST_DATA;
            r_baud    <= CNT_W'(0);
            r_bit_idx <= IDX_W'(0);
            r_txd     <= r_shift[0];
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (r_baud == BIT_LAST) begin
            r_baud <= CNT_W'(0);
            if (r_bit_idx == IDX_LAST) begin
              if (HAS_PAR) begin
                r_state <= ST_PAR;
                r_txd   <= r_par;
              end else begin
                r_state <= ST_STOP;
                r_txd   <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
              r_txd     <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end
        ST_PAR: begin
          if (r_baud == BIT_LAST) begin
            r_state <= ST_STOP;
            r_baud  <= CNT_W'(0);
            r_txd   <= 1'b1;
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (w_stop_done) begin
            r_baud <= CNT_W'(0);
            if (w_pop) begin
              // Next word goes out with no idle gap after the stop bit(s).
              r_state <= ST_START;
              r_shift <= w_head;
              r_par   <= parity_bit(w_head);
              r_txd   <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_txd   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_baud  <= CNT_W'(0);
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready     = w_ready;
  assign uart_txd     = r_txd;
  assign uart_tx_busy = r_busy;
  assign fifo_count   = r_count;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg at BIT_CYC = 10.
// Four instances cover 8N1 (FIFO/reset tests too), 7E1, 7O1 and 8N2.
module tb_uart_tx_cfg;

  localparam int BIT_CYC = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d8;
  logic [6:0] d7;
  logic       v_a, v_b, v_c, v_d;
  logic       rdy_a, txd_a, busy_a;
  logic       rdy_b, txd_b, busy_b;
  logic       rdy_c, txd_c, busy_c;
  logic       rdy_d, txd_d, busy_d;
  logic [2:0] cnt_a, cnt_b, cnt_c, cnt_d;

  int         sel;
  logic       txd_m, busy_m;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         busy_cnt = 0;
  int         bad;
  logic [7:0] w4 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .tx_valid(v_a), .tx_data(d8), .tx_ready(rdy_a),
    .uart_txd(txd_a), .uart_tx_busy(busy_a), .fifo_count(cnt_a));

  uart_tx_cfg #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(7),
                .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_valid(v_b), .tx_data(d7), .tx_ready(rdy_b),
    .uart_txd(txd_b), .uart_tx_busy(busy_b), .fifo_count(cnt_b));

  uart_tx_cfg #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(7),
                .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .tx_valid(v_c), .tx_data(d7), .tx_ready(rdy_c),
    .uart_txd(txd_c), .uart_tx_busy(busy_c), .fifo_count(cnt_c));

  uart_tx_cfg #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
    .clk(clk), .rst_n(rst_n), .tx_valid(v_d), .tx_data(d8), .tx_ready(rdy_d),
    .uart_txd(txd_d), .uart_tx_busy(busy_d), .fifo_count(cnt_d));

  // Select which instance's line the frame checker watches
  always_comb begin
    txd_m  = txd_a;
    busy_m = busy_a;
    case (sel)
      1:       begin txd_m = txd_b; busy_m = busy_b; end
      2:       begin txd_m = txd_c; busy_m = busy_c; end
      3:       begin txd_m = txd_d; busy_m = busy_d; end
      default: begin txd_m = txd_a; busy_m = busy_a; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the negedge holding the first sample of the start bit.
  task automatic expect_line(input string tag, input logic [19:0] bits, input int nbits);
    int good;
    for (int b = 0; b < nbits; b++) begin
      good = 0;
      for (int c = 0; c < BIT_CYC; c++) begin
        if (txd_m === bits[b]) good++;
        if (busy_m === 1'b1) busy_cnt++;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", tag, b), good, BIT_CYC);
    end
  endtask

  // 8N1 line pattern, LSB first: start 0, data, stop 1
  function automatic logic [19:0] f8n1(input logic [7:0] d);
    return {10'b0, 1'b1, d, 1'b0};
  endfunction

  initial begin
    rst_n = 1'b0; v_a = 1'b0; v_b = 1'b0; v_c = 1'b0; v_d = 1'b0;
    d8 = 8'h00; d7 = 7'h00; sel = 0;
    repeat (3) @(negedge clk);
    check("rst_txd",   32'(txd_a),  32'd1);
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_count", 32'(cnt_a),  32'd0);
    check("rst_ready", 32'(rdy_a),  32'd1);
    check("rst_txd_d", 32'(txd_d),  32'd1);
    rst_n = 1'b1;

    // 8N1, 0x55
    repeat (2) @(negedge clk);
    d8 = 8'h55; v_a = 1'b1;
    @(negedge clk);
    v_a = 1'b0;
    check("t1_count_after_push", 32'(cnt_a), 32'd1);
    check("t1_txd_before_start", 32'(txd_a), 32'd1);
    @(negedge clk);
    busy_cnt = 0;
    expect_line("t1", 20'b0000000000_1010101010, 10);
    check("t1_busy_cycles", busy_cnt, 32'd100);
    check("t1_txd_idle", 32'(txd_a), 32'd1);
    check("t1_busy_idle", 32'(busy_a), 32'd0);

    // 7E1 and 7O1, 0x03: data 1100000, parity 0 / 1
    sel = 1;
    repeat (2) @(negedge clk);
    d7 = 7'h03; v_b = 1'b1;
    @(negedge clk);
    v_b = 1'b0;
    @(negedge clk);
    expect_line("t2even", 20'b0000000000_1000000110, 10);
    check("t2even_idle", 32'(txd_b), 32'd1);
    sel = 2;
    repeat (2) @(negedge clk);
    v_c = 1'b1;
    @(negedge clk);
    v_c = 1'b0;
    @(negedge clk);
    expect_line("t2odd", 20'b0000000000_1100000110, 10);
    check("t2odd_idle", 32'(txd_c), 32'd1);

    // 8N2, 0xA5 twice back-to-back, second frame with no gap
    sel = 3;
    repeat (2) @(negedge clk);
    d8 = 8'hA5; v_d = 1'b1;
    @(negedge clk);
    check("t3_count", 32'(cnt_d), 32'd1);
    @(negedge clk);
    v_d = 1'b0;
    expect_line("t3a", 20'b000000000_11_1010_0101_0, 11);
    expect_line("t3b", 20'b000000000_11_1010_0101_0, 11);
    check("t3_txd_idle", 32'(txd_d), 32'd1);
    check("t3_busy_idle", 32'(busy_d), 32'd0);

    // Six pushes into a depth-4 FIFO while idle: sixth word dropped
    sel = 0;
    repeat (2) @(negedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          d8 = w4[i]; v_a = 1'b1;
          @(negedge clk);
          if (i == 1) begin
            check("t4_count_pushpop", 32'(cnt_a), 32'd1);
          end else if (i == 4) begin
            check("t4_count_full", 32'(cnt_a), 32'd4);
            check("t4_ready_full", 32'(rdy_a), 32'd0);
          end else if (i == 5) begin
            check("t4_count_drop", 32'(cnt_a), 32'd4);
          end
        end
        v_a = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        for (int f = 0; f < 5; f++) begin
          expect_line($sformatf("t4f%0d", f), f8n1(w4[f]), 10);
        end
      end
    join
    check("t4_txd_idle", 32'(txd_a), 32'd1);
    check("t4_busy_idle", 32'(busy_a), 32'd0);
    check("t4_count_empty", 32'(cnt_a), 32'd0);

    // Reset at cycle 35 of a frame, second word queued and discarded
    repeat (2) @(negedge clk);
    d8 = 8'h0B; v_a = 1'b1;
    @(negedge clk);
    d8 = 8'h3C;
    @(negedge clk);
    v_a = 1'b0;
    repeat (34) @(negedge clk);
    check("t5_txd_bit2", 32'(txd_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_txd", 32'(txd_a), 32'd1);
    check("t5_count", 32'(cnt_a), 32'd0);
    check("t5_busy", 32'(busy_a), 32'd0);
    check("t5_ready", 32'(rdy_a), 32'd1);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    check("t5_no_frames", bad, 32'd0);

    // Push on the same edge as the end-of-stop pop with two words queued
    for (int i = 0; i < 3; i++) begin
      d8 = 8'h81 >> i; v_a = 1'b1;
      @(negedge clk);
    end
    v_a = 1'b0;
    check("t6_count_pre", 32'(cnt_a), 32'd2);
    repeat (98) @(negedge clk);
    d8 = 8'h99; v_a = 1'b1;
    check("t6_count_stop", 32'(cnt_a), 32'd2);
    check("t6_txd_stop", 32'(txd_a), 32'd1);
    @(negedge clk);
    v_a = 1'b0;
    check("t6_count_pushpop", 32'(cnt_a), 32'd2);
    check("t6_txd_next_start", 32'(txd_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
